// File: rtl/uart_pkg.sv
// uart_pkg: baud rates, divisor helper, parity encodings and frame FSM states for uart_tx_frame
package uart_pkg;
  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_38400  = 38400;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  function automatic logic [31:0] baud_div(input int unsigned clk_freq, input int unsigned baud);
    return 32'(clk_freq / baud);
  endfunction
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: valid/ready word handshake (Data_in, Data_valid from master; Data_ready from slave)
interface uart_tx_frame_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] Data_in;
  logic              Data_valid;
  logic              Data_ready;
  modport master (output Data_in, output Data_valid, input Data_ready);
  modport slave (input Data_in, input Data_valid, output Data_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous word FIFO with registered read; ports clk, rst, push, pop, wr_data, rd_data, full, empty, count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = rd_data_q;
  assign count   = count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wr_data;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_data_q <= mem_q[rptr_q];
        rptr_q    <= rptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: queued UART transmitter; in_if word handshake in, Baud_sel/Parity_mode/Stop_bits config, Uart_tx line, Uart_tx_done pulse, Uart_state busy, Fifo_count queued words
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  uart_tx_frame_if.slave                in_if,
  input  logic [2:0]                    Baud_sel,
  input  logic [1:0]                    Parity_mode,
  input  logic                          Stop_bits,
  output logic                          Uart_tx,
  output logic                          Uart_tx_done,
  output logic                          Uart_state,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_count
);
  localparam int unsigned CF = CLK_FREQ;
  state_t            state_q;
  logic [31:0]       cnt_q, div_q, sel_div;
  logic [3:0]        bit_q;
  logic [DATA_W-1:0] sh_q, rd_data;
  logic [1:0]        pm_q;
  logic              sb_q, par_q, tx_q, done_q, busy_q;
  logic              bit_end, stop_end, has_par, pop, fifo_full, fifo_empty;
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk), .rst(Rst), .push(in_if.Data_valid), .pop(pop), .wr_data(in_if.Data_in),
    .rd_data(rd_data), .full(fifo_full), .empty(fifo_empty), .count(Fifo_count)
  );
  assign in_if.Data_ready = ~fifo_full;
  assign Uart_tx          = tx_q;
  assign Uart_tx_done     = done_q;
  assign Uart_state       = busy_q;
  always_comb begin
    sel_div  = Baud_sel == 3'd0 ? baud_div(CF, BAUD_9600) :
               Baud_sel == 3'd1 ? baud_div(CF, BAUD_19200) :
               Baud_sel == 3'd2 ? baud_div(CF, BAUD_38400) :
               Baud_sel == 3'd3 ? baud_div(CF, BAUD_57600) : baud_div(CF, BAUD_115200);
    bit_end  = cnt_q == div_q - 32'd1;
    stop_end = bit_end && bit_q == {3'b000, sb_q};
    has_par  = pm_q == PAR_ODD || pm_q == PAR_EVEN;
    pop      = !fifo_empty && (state_q == S_IDLE || (state_q == S_STOP && stop_end));
  end
  // Line outputs are registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      div_q   <= baud_div(CF, BAUD_115200);
      pm_q    <= PAR_NONE;
      sb_q    <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tx_q   <= state_q == S_START ? 1'b0 : state_q == S_DATA ? sh_q[0] : state_q == S_PARITY ? par_q : 1'b1;
      done_q <= state_q == S_STOP && stop_end;
      busy_q <= state_q != S_IDLE;
      cnt_q  <= (state_q == S_IDLE || bit_end) ? '0 : cnt_q + 32'd1;
      if (pop) begin
        div_q <= sel_div;
        pm_q  <= Parity_mode;
        sb_q  <= Stop_bits;
      end
      if (state_q == S_START) begin
        sh_q  <= rd_data;
        par_q <= pm_q == PAR_EVEN ? ^rd_data : ~^rd_data;
      end
      if (state_q == S_DATA && bit_end) sh_q <= sh_q >> 1;
      case (state_q)
        S_IDLE:   if (pop) state_q <= S_START;
        S_START:  if (bit_end) state_q <= S_DATA;
        S_DATA:   if (bit_end) begin
          bit_q <= bit_q == 4'(DATA_W - 1) ? '0 : bit_q + 4'd1;
          if (bit_q == 4'(DATA_W - 1)) state_q <= has_par ? S_PARITY : S_STOP;
        end
        S_PARITY: if (bit_end) state_q <= S_STOP;
        S_STOP:   if (bit_end) begin
          bit_q <= stop_end ? '0 : bit_q + 4'd1;
          if (stop_end) state_q <= pop ? S_START : S_IDLE;
        end
        default:  state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed scoreboard bench for uart_tx_frame (8-bit and 5-bit builds)
module tb_uart_tx_frame;
  localparam int CLK = 50_000_000;
  localparam int TMO = 10000;
  typedef struct {
    logic [7:0] data;
    int         dw;
    int         div;
    logic       par;
    logic       pbit;
    logic       sb;
  } exp_t;
  exp_t sbq[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [2:0] baud = 3'd4;
  logic [1:0] pm = 2'b00;
  logic       sb = 1'b0;
  logic       vld = 1'b0;
  logic       sel5 = 1'b0;
  logic [7:0] din = '0;
  int checks = 0;
  int fails = 0;
  logic tx8, done8, st8, tx5, done5, st5;
  logic [3:0] cnt8, cnt5;
  logic tx_m, done_m, st_m, rdy_m;
  uart_tx_frame_if #(.DATA_W(8)) if8 ();
  uart_tx_frame_if #(.DATA_W(5)) if5 ();
  assign if8.Data_in    = din;
  assign if8.Data_valid = vld & ~sel5;
  assign if5.Data_in    = din[4:0];
  assign if5.Data_valid = vld & sel5;
  assign tx_m   = sel5 ? tx5 : tx8;
  assign done_m = sel5 ? done5 : done8;
  assign st_m   = sel5 ? st5 : st8;
  assign rdy_m  = sel5 ? if5.Data_ready : if8.Data_ready;
  uart_tx_frame #(.CLK_FREQ(CLK), .DATA_W(8), .FIFO_DEPTH(8)) dut (
    .Clk(clk), .Rst(rst), .in_if(if8), .Baud_sel(baud), .Parity_mode(pm), .Stop_bits(sb),
    .Uart_tx(tx8), .Uart_tx_done(done8), .Uart_state(st8), .Fifo_count(cnt8)
  );
  uart_tx_frame #(.CLK_FREQ(CLK), .DATA_W(5), .FIFO_DEPTH(8)) dut5 (
    .Clk(clk), .Rst(rst), .in_if(if5), .Baud_sel(baud), .Parity_mode(pm), .Stop_bits(sb),
    .Uart_tx(tx5), .Uart_tx_done(done5), .Uart_state(st5), .Fifo_count(cnt5)
  );
  function automatic int bdiv(input logic [2:0] s);
    return s == 3'd0 ? 5208 : s == 3'd1 ? 2604 : s == 3'd2 ? 1302 : s == 3'd3 ? 868 : 434;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic push_word(input logic [7:0] d);
    int t;
    exp_t e;
    logic [7:0] m;
    t = 0;
    din = d;
    vld = 1'b1;
    while (rdy_m !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk("push_ready", rdy_m, 1);
    @(negedge clk);
    e.dw   = sel5 ? 5 : 8;
    m      = sel5 ? 8'h1F : 8'hFF;
    e.data = d & m;
    e.div  = bdiv(baud);
    e.par  = pm == 2'b01 || pm == 2'b10;
    e.pbit = pm == 2'b10 ? ^(d & m) : ~^(d & m);
    e.sb   = sb;
    sbq.push_back(e);
  endtask
  task automatic check_frame(input int maxbits, input bit contig);
    exp_t e;
    int t, nb, len, done_pos, dn, idx;
    logic expb, obsb, stv;
    t = 0;
    done_pos = -1;
    dn = 0;
    idx = 0;
    while (tx_m !== 1'b0 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk("frame_start", tx_m, 0);
    if (contig) chk("frame_gap", t, 0);
    if (tx_m !== 1'b0) return;
    chk("sb_nonempty", sbq.size() > 0, 1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    nb = 2 + e.dw + int'(e.par) + int'(e.sb);
    len = nb * e.div;
    for (int b = 0; b < nb && b < maxbits; b++) begin
      expb = b == 0 ? 1'b0 : b <= e.dw ? e.data[b-1] : (e.par && b == e.dw + 1) ? e.pbit : 1'b1;
      obsb = expb;
      stv = 1'b1;
      for (int c = 0; c < e.div; c++) begin
        if (tx_m !== expb) obsb = tx_m;
        if (st_m !== 1'b1) stv = st_m;
        if (done_m === 1'b1) begin
          dn++;
          if (done_pos < 0) done_pos = idx;
        end
        idx++;
        @(negedge clk);
      end
      chk($sformatf("bit%0d_data%0h", b, e.data), obsb, expb);
      chk($sformatf("busy_bit%0d", b), stv, 1);
    end
    if (maxbits >= nb) begin
      chk("done_pos", done_pos, len - 1);
      chk("done_cnt", dn, 1);
    end
  endtask
  initial begin
    logic txo;
    int dn;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx8", tx8, 1);
    chk("rst_done8", done8, 0);
    chk("rst_st8", st8, 0);
    chk("rst_cnt8", cnt8, 0);
    chk("rst_rdy8", if8.Data_ready, 1);
    chk("rst_tx5", tx5, 1);
    chk("rst_cnt5", cnt5, 0);
    // single 8N1 frame with accept-to-start latency
    push_word(8'h55);
    vld = 1'b0;
    chk("s1_cnt_k", cnt8, 1);
    chk("s1_tx_k", tx8, 1);
    @(negedge clk);
    chk("s1_tx_k1", tx8, 1);
    chk("s1_cnt_k1", cnt8, 0);
    @(negedge clk);
    chk("s1_tx_k2", tx8, 0);
    chk("s1_st_k2", st8, 1);
    check_frame(99, 1);
    chk("s1_idle_tx", tx8, 1);
    chk("s1_idle_st", st8, 0);
    // parity and stop bits
    pm = 2'b10;
    push_word(8'h07);
    vld = 1'b0;
    check_frame(99, 0);
    pm = 2'b01;
    sb = 1'b1;
    push_word(8'h07);
    vld = 1'b0;
    check_frame(99, 0);
    pm = 2'b00;
    sb = 1'b0;
    // FIFO full and contiguous frames
    fork
      begin
        for (int i = 0; i < 9; i++) push_word(8'(8'h30 + i * 7));
        chk("s3_ready_low", rdy_m, 0);
        chk("s3_count_full", cnt8, 8);
        din = 8'hEE;
        repeat (3) @(negedge clk);
        chk("s3_push_ignored", cnt8, 8);
        vld = 1'b0;
      end
      begin
        check_frame(99, 0);
        for (int i = 1; i < 9; i++) check_frame(99, 1);
      end
    join
    chk("s3_sb_empty", sbq.size(), 0);
    // mid-frame baud change only affects the next frame
    fork
      begin
        push_word(8'hA5);
        vld = 1'b0;
        repeat (1000) @(negedge clk);
        baud = 3'd0;
        push_word(8'h3C);
        vld = 1'b0;
      end
      begin
        check_frame(99, 0);
        check_frame(2, 1);
      end
    join
    baud = 3'd4;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    // reset mid-frame with words queued
    for (int i = 0; i < 4; i++) push_word(8'(8'h11 * (i + 1)));
    vld = 1'b0;
    repeat (700) @(negedge clk);
    chk("s5_cnt_before", cnt8, 3);
    chk("s5_busy_before", st8, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("s5_tx", tx8, 1);
    chk("s5_st", st8, 0);
    chk("s5_cnt", cnt8, 0);
    chk("s5_rdy", if8.Data_ready, 1);
    rst = 1'b0;
    sbq.delete();
    txo = 1'b1;
    dn = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (tx8 !== 1'b1) txo = tx8;
      if (done8 === 1'b1) dn++;
    end
    chk("s5_quiet_tx", txo, 1);
    chk("s5_no_done", dn, 0);
    chk("s5_cnt_after", cnt8, 0);
    // 5-bit build with even parity
    sel5 = 1'b1;
    pm = 2'b10;
    push_word(8'h1F);
    vld = 1'b0;
    check_frame(99, 0);
    chk("s6_idle_tx", tx5, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
